// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg
//   Shared constants for the multicycle ARM control unit: FSM state codes,
//   mux-select and ALU encodings, condition codes and the ALU decode helper.
//   No ports. Used by arm_mc_controller and arm_mc_cond_unit.
package arm_mc_pkg;

  // FSM state codes
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ALUSrcA / ALUSrcB / ResultSrc encodings
  localparam logic [1:0] SRCA_REG      = 2'b00;
  localparam logic [1:0] SRCA_PC       = 2'b01;
  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Opcode classes (instruction bits [27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Data-processing cmd field (Funct[4:1]) to ALU operation; unknown cmds add.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/arm_mc_cond_unit.sv
// arm_mc_cond_unit
//   NZCV flags register and ARM condition evaluation.
//   Ports:
//     clk, reset_n  clock / asynchronous active-low reset
//     Cond          condition field of the current instruction
//     ALUFlags      NZCV from the ALU this cycle
//     FlagW         [1] loads N,Z   [0] loads C,V
//     flag_upd      high in the execute cycle; flags load on its closing edge
//     cond_ex       condition passes against the current (pre-update) flags
module arm_mc_cond_unit
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       flag_upd,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;   // 1111 never executes
    endcase
  end

  // A failed condition also blocks the flag update.
  always_comb begin
    flags_d = flags_q;
    if (flag_upd && cond_ex) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flags_q <= RESET_FLAGS;
    else          flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller
//   Control unit for a multicycle ARM datapath sharing one memory for
//   instructions and data. One FSM state per cycle; every architectural
//   write is gated by the condition result from arm_mc_cond_unit.
//   Ports:
//     clk, reset_n               clock / asynchronous active-low reset
//     Cond, Op, Funct, Rd        fields of the instruction register
//     ALUFlags                   NZCV from the ALU
//     PCWrite, MemWrite, RegWrite, IRWrite   write strobes
//     AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl  selects
//   Optional: define ARM_MC_MEMWAIT_EN to add input mem_ready; FETCH, MEMREAD
//   and MEMWRITE then hold until mem_ready=1 and only strobe in that cycle.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
`ifdef ARM_MC_MEMWAIT_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  state_t     state_q, state_d;
  logic       mem_rdy;
  logic       pc_fetch, ir_w, reg_w, mem_w, branch, flag_upd;
  logic       cond_ex, rd_pc;
  logic [1:0] alu_op, flag_w;

`ifdef ARM_MC_MEMWAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign alu_op = alu_decode(Funct[4:1]);
  // Logical ops leave C and V untouched.
  assign flag_w = {Funct[0], Funct[0] & ((alu_op == ALU_ADD) | (alu_op == ALU_SUB))};
  assign rd_pc  = (Rd == 4'd15);

  assign ImmSrc = Op;
  // Branches read R15 as Rn; stores read Rd as the second operand.
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

  always_comb begin
    state_d    = state_q;
    pc_fetch   = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    flag_upd   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_REG;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_w      = mem_rdy;
        pc_fetch  = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = mem_rdy;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUControl = alu_op;
        flag_upd   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_op;
        flag_upd   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        reg_w     = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  arm_mc_cond_unit #(
    .RESET_FLAGS (RESET_FLAGS)
  ) u_cond (
    .clk      (clk),
    .reset_n  (reset_n),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (flag_w),
    .flag_upd (flag_upd),
    .cond_ex  (cond_ex)
  );

  // Strobes are qualified with reset_n so nothing writes while reset is held,
  // even though the FSM already sits in FETCH.
  assign RegWrite = reset_n & reg_w & cond_ex & ~rd_pc;
  assign MemWrite = reset_n & mem_w & cond_ex;
  assign IRWrite  = reset_n & ir_w;
  assign PCWrite  = reset_n & (pc_fetch | (branch & cond_ex) | (reg_w & cond_ex & rd_pc));

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller
//   Randomized and directed stimulus for arm_mc_controller, checked against an
//   instruction-level model: each instruction expands into its list of cycles,
//   and each cycle's expected controls follow from the state name, the model
//   NZCV flags and the instruction fields. Honours ARM_MC_MEMWAIT_EN.
`timescale 1ns/1ps
module tb_arm_mc_controller;

  typedef enum int {T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB,
                    T_MEMWRITE, T_EXR, T_EXI, T_ALUWB, T_BRANCH} tst_e;

  localparam logic [3:0] RESET_FLAGS = 4'b0000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
`ifdef ARM_MC_MEMWAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  int    checks = 0;
  int    errors = 0;
  string cur_instr = "reset";
  logic  m_n, m_z, m_c, m_v;   // model flags

  always #5 clk = ~clk;

  arm_mc_controller #(.RESET_FLAGS(RESET_FLAGS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
`ifdef ARM_MC_MEMWAIT_EN
    .mem_ready  (mem_ready),
`endif
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s [%s]: got %h, want %h", tag, cur_instr, obs, exp);
    end
  endtask

  // ARM condition semantics on the model flags.
  function automatic logic cond_ok(input logic [3:0] c);
    case (c)
      4'd0:    return m_z;
      4'd1:    return !m_z;
      4'd2:    return m_c;
      4'd3:    return !m_c;
      4'd4:    return m_n;
      4'd5:    return !m_n;
      4'd6:    return m_v;
      4'd7:    return !m_v;
      4'd8:    return m_c && !m_z;
      4'd9:    return !m_c || m_z;
      4'd10:   return m_n == m_v;
      4'd11:   return m_n != m_v;
      4'd12:   return !m_z && (m_n == m_v);
      4'd13:   return m_z || (m_n != m_v);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 0 ADD, 1 SUB, 2 AND, 3 ORR
  function automatic logic [1:0] alu_of(input logic [5:0] f);
    case (f[4:1])
      4'b0010: return 2'd1;
      4'b0000: return 2'd2;
      4'b1100: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic update_flags();
    logic ce;
    ce = cond_ok(Cond);
    if (ce && Funct[0]) begin
      m_n = ALUFlags[3];
      m_z = ALUFlags[2];
      if (alu_of(Funct) <= 2'd1) begin
        m_c = ALUFlags[1];
        m_v = ALUFlags[0];
      end
    end
  endtask

  // Compare every control the specification defines for this cycle.
  task automatic check_state(input tst_e st, input bit in_rst, input bit ready, input string tag);
    logic pcw, mw, rw, irw, adr, ce, wb;
    logic [1:0] sa, sb, rs, ac;
    logic k_adr, k_sa, k_sb, k_rs, k_ac;
    logic [15:0] e, m, o;
    ce  = cond_ok(Cond);
    wb  = (st == T_MEMWB) || (st == T_ALUWB);
    pcw = ((st == T_FETCH) && ready) || ((st == T_BRANCH) && ce) || (wb && ce && Rd == 4'd15);
    mw  = (st == T_MEMWRITE) && ce && ready;
    rw  = wb && ce && (Rd != 4'd15);
    irw = (st == T_FETCH) && ready;
    if (in_rst) {pcw, mw, rw, irw} = 4'b0000;
    {adr, sa, sb, rs, ac} = '0;
    {k_adr, k_sa, k_sb, k_rs, k_ac} = '0;
    case (st)
      T_FETCH:    begin adr = 0; sa = 1; sb = 2; rs = 2; ac = 0; {k_adr, k_sa, k_sb, k_rs, k_ac} = 5'b11111; end
      T_DECODE:   begin sa = 1; sb = 2; rs = 2; ac = 0; {k_sa, k_sb, k_rs, k_ac} = 4'b1111; end
      T_MEMADR:   begin sa = 0; sb = 1; ac = 0; {k_sa, k_sb, k_ac} = 3'b111; end
      T_MEMREAD:  begin adr = 1; k_adr = 1; end
      T_MEMWRITE: begin adr = 1; k_adr = 1; end
      T_MEMWB:    begin rs = 1; k_rs = 1; end
      T_ALUWB:    begin rs = 0; k_rs = 1; end
      T_EXR:      begin sa = 0; sb = 0; ac = alu_of(Funct); {k_sa, k_sb, k_ac} = 3'b111; end
      T_EXI:      begin sa = 0; sb = 1; ac = alu_of(Funct); {k_sa, k_sb, k_ac} = 3'b111; end
      default:    begin sa = 0; sb = 1; ac = 0; rs = 2; {k_sa, k_sb, k_rs, k_ac} = 4'b1111; end
    endcase
    e = {pcw, mw, rw, irw, adr, sa, sb, rs, Op, ac};
    m = {4'hF, k_adr, {2{k_sa}}, {2{k_sb}}, {2{k_rs}}, 2'b11, {2{k_ac}}};
    o = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
    chk(tag, {16'h0, o & m}, {16'h0, e & m});
  endtask

  // One architectural state; memory states may be held for 'stall' cycles.
  task automatic step(input tst_e st, input int stall, input string tag);
    int n;
    bit rdy;
    n = stall;
`ifndef ARM_MC_MEMWAIT_EN
    n = 0;
`endif
    for (int w = 0; w <= n; w++) begin
      rdy = (w == n);
`ifdef ARM_MC_MEMWAIT_EN
      mem_ready = rdy;
`endif
      #4;
      check_state(st, 1'b0, rdy, rdy ? tag : {tag, "_wait"});
      if (rdy && (st == T_EXR || st == T_EXI)) update_flags();
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] af,
                           input int fetch_stall, input int mem_stall);
    Cond = c; Op = op; Funct = f; Rd = rd; ALUFlags = af;
    cur_instr = $sformatf("cond=%h op=%0d funct=%b rd=%0d", c, op, f, rd);
    step(T_FETCH, fetch_stall, "fetch");
    step(T_DECODE, 0, "decode");
    case (op)
      2'b01: begin
        step(T_MEMADR, 0, "memadr");
        if (f[0]) begin
          step(T_MEMREAD, mem_stall, "memread");
          step(T_MEMWB, 0, "memwb");
        end else begin
          step(T_MEMWRITE, mem_stall, "memwrite");
        end
      end
      2'b00: begin
        step(f[5] ? T_EXI : T_EXR, 0, "execute");
        step(T_ALUWB, 0, "aluwb");
      end
      2'b10: step(T_BRANCH, 0, "branch");
      default: ;
    endcase
    $display("instr %s aluflags=%b -> model nzcv=%b%b%b%b", cur_instr, af, m_n, m_z, m_c, m_v);
  endtask

  // Store aborted by reset in its MEMADR cycle.
  task automatic str_with_reset();
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd4; ALUFlags = 4'h0;
    cur_instr = "STR aborted by reset";
    step(T_FETCH, 0, "fetch");
    step(T_DECODE, 0, "decode");
    #4;
    check_state(T_MEMADR, 1'b0, 1'b1, "memadr");
    reset_n = 1'b0;
    #1;
    check_state(T_FETCH, 1'b1, 1'b1, "rst_assert");
    @(posedge clk); #4;
    check_state(T_FETCH, 1'b1, 1'b1, "rst_hold");
    @(posedge clk); #1;
    reset_n = 1'b1;
    {m_n, m_z, m_c, m_v} = RESET_FLAGS;
    $display("instr %s", cur_instr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] f;
    logic [3:0] c, rd;
    logic [1:0] op;
    reset_n = 1'b0;
    Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; ALUFlags = 4'h0;
`ifdef ARM_MC_MEMWAIT_EN
    mem_ready = 1'b1;
`endif
    {m_n, m_z, m_c, m_v} = RESET_FLAGS;
    repeat (2) @(posedge clk);
    #4;
    check_state(T_FETCH, 1'b1, 1'b1, "reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed sequences
    run_instr(4'hE, 2'b00, 6'b101000, 4'd3, 4'h0, 0, 0);   // ADD imm
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'h0, 0, 0);   // LDR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'h0, 0, 0);   // STR
    run_instr(4'hE, 2'b00, 6'b000101, 4'd5, 4'b0100, 0, 0); // SUBS -> Z
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 0, 0);   // BEQ taken
    run_instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'h0, 0, 0);   // BNE not taken
    str_with_reset();
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0, 0, 0);   // BEQ after reset: Z cleared
    run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, 0, 0);  // ADD to PC
    run_instr(4'hF, 2'b00, 6'b001001, 4'd1, 4'hF, 0, 0);   // never-executes
    run_instr(4'hE, 2'b11, 6'b000000, 4'd1, 4'h0, 0, 0);   // undefined opcode
    run_instr(4'hE, 2'b00, 6'b101000, 4'd6, 4'h0, 3, 0);   // FETCH held 3 cycles
    run_instr(4'hE, 2'b01, 6'b011000, 4'd7, 4'h0, 0, 2);   // STR with memory wait

    // Random instructions
    for (int i = 0; i < 250; i++) begin
      c  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      f  = 6'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: f[4:1] = 4'b0100;
          1: f[4:1] = 4'b0010;
          2: f[4:1] = 4'b0000;
          default: f[4:1] = 4'b1100;
        endcase
      end
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      run_instr(c, op, f, rd, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
